// File: rtl/issue_dispatch_n_pkg.sv
// Shared types for the in-order N-wide issue stage: decoded slot, forward port and issued group entry.
package issue_dispatch_n_pkg;
   localparam int ISSUE_WIDTH_DEF = 2;
   localparam int FWD_STAGES_DEF  = 3;
   localparam int LAT_W_DEF       = 3;
   localparam int NREGS_DEF       = 32;
   localparam int XLEN            = 32;
   localparam int REG_W           = 5;

   typedef struct packed {
      logic                       valid;
      logic [XLEN-1:0]            pc;
      logic [1:0][REG_W-1:0]      rs;
      logic [1:0]                 rs_en;
      logic [REG_W-1:0]           rd;
      logic                       rd_en;
      logic [XLEN-1:0]            imm;
      logic [LAT_W_DEF-1:0]       lat;
      logic                       is_mem;
      logic                       is_serial;
      logic [7:0]                 op;
   } slot_t;

   typedef struct packed {
      logic                       we;
      logic [REG_W-1:0]           addr;
      logic [XLEN-1:0]            data;
   } fwd_t;

   typedef struct packed {
      logic                       valid;
      logic [XLEN-1:0]            pc;
      logic [7:0]                 op;
      logic [1:0][XLEN-1:0]       src;
      logic [REG_W-1:0]           rd;
      logic                       rd_en;
   } issue_t;

   // A write to r0 never matches anything: it is hard-wired zero.
   function automatic logic reg_hit(input logic en, input logic [REG_W-1:0] wr,
                                    input logic [REG_W-1:0] rd_reg);
      return en && (wr != '0) && (wr == rd_reg);
   endfunction
endpackage

// File: rtl/issue_dispatch_n_if.sv
// Decode-queue / forwarding / EX bundle seen by the issue stage.
interface issue_dispatch_n_if
   import issue_dispatch_n_pkg::*;
#(
   parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEF,
   parameter int FWD_STAGES  = FWD_STAGES_DEF
) ();
   slot_t  [ISSUE_WIDTH-1:0]                  slot_i;
   logic   [ISSUE_WIDTH-1:0][1:0][XLEN-1:0]   rf_data_i;
   fwd_t   [FWD_STAGES-1:0][ISSUE_WIDTH-1:0]  fwd_i;
   logic   [ISSUE_WIDTH-1:0]                  accept_o;
   logic                                      stall_o;
   issue_t [ISSUE_WIDTH-1:0]                  ex_o;

   modport master (output slot_i, rf_data_i, fwd_i, input accept_o, stall_o, ex_o);
   modport slave  (input slot_i, rf_data_i, fwd_i, output accept_o, stall_o, ex_o);
endinterface

// File: rtl/issue_dispatch_n_scoreboard.sv
// Per-register countdown scoreboard: a register stays busy until its multi-cycle producer's counter drains.
module issue_scoreboard
   import issue_dispatch_n_pkg::*;
#(
   parameter int NREGS       = NREGS_DEF,
   parameter int LAT_W       = LAT_W_DEF,
   parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEF
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 clr,
   input  logic                                 hold,
   input  logic [ISSUE_WIDTH-1:0]               set_en,
   input  logic [ISSUE_WIDTH-1:0][REG_W-1:0]    set_rd,
   input  logic [ISSUE_WIDTH-1:0][LAT_W-1:0]    set_lat,
   output logic [NREGS-1:0]                     busy
);
   logic [LAT_W-1:0] cnt_p1 [NREGS];
   logic [LAT_W-1:0] cnt_d  [NREGS];

   // Decrement first, then new producers overwrite; ascending lane order lets the higher lane win.
   always_comb begin
      for (int r = 0; r < NREGS; r++)
         cnt_d[r] = (cnt_p1[r] != '0) ? cnt_p1[r] - LAT_W'(1) : '0;
      for (int k = 0; k < ISSUE_WIDTH; k++)
         if (set_en[k] && set_rd[k] != '0 && set_lat[k] > LAT_W'(1))
            cnt_d[set_rd[k]] = set_lat[k] - LAT_W'(1);
      cnt_d[0] = '0;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int r = 0; r < NREGS; r++) cnt_p1[r] <= '0;
      end else if (!hold) begin
         cnt_p1 <= cnt_d;
      end
   end

   always_comb
      for (int r = 0; r < NREGS; r++) busy[r] = (cnt_p1[r] != '0);
endmodule

// File: rtl/issue_dispatch_n.sv
// In-order N-wide issue: picks the longest legal prefix of decoded slots, resolves operands
// through the forwarding network and registers the issued group into EX.
module issue_dispatch_n
   import issue_dispatch_n_pkg::*;
#(
   parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEF,
   parameter int FWD_STAGES  = FWD_STAGES_DEF,
   parameter int LAT_W       = LAT_W_DEF,
   parameter int NREGS       = NREGS_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pause,
   input  logic              flush,
   issue_dispatch_n_if.slave iss,
   output logic [31:0]       stall_cnt_o
);
   logic [ISSUE_WIDTH-1:0]                  legal;
   logic [ISSUE_WIDTH-1:0]                  accept;
   logic [NREGS-1:0]                        busy;
   logic [ISSUE_WIDTH-1:0][1:0][XLEN-1:0]   opnd;
   issue_t [ISSUE_WIDTH-1:0]                issue_d;
   issue_t [ISSUE_WIDTH-1:0]                ex_p1;
   logic [ISSUE_WIDTH-1:0]                  sb_set;
   logic [ISSUE_WIDTH-1:0][REG_W-1:0]       sb_rd;
   logic [ISSUE_WIDTH-1:0][LAT_W-1:0]       sb_lat;
   logic                                    go;

   assign go = !pause && !flush && !rst;

   // Legality is a prefix: once a slot fails, every younger slot fails with it.
   always_comb begin
      logic ok, prev_ok, mem_seen;
      legal    = '0;
      prev_ok  = 1'b1;
      mem_seen = 1'b0;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         ok = iss.slot_i[k].valid && prev_ok;
         for (int j = 0; j < 2; j++) begin
            if (iss.slot_i[k].rs_en[j] && iss.slot_i[k].rs[j] != '0 && busy[iss.slot_i[k].rs[j]])
               ok = 1'b0;
            for (int e = 0; e < k; e++)
               if (iss.slot_i[k].rs_en[j] &&
                   reg_hit(iss.slot_i[e].rd_en, iss.slot_i[e].rd, iss.slot_i[k].rs[j]))
                  ok = 1'b0;
         end
         if (iss.slot_i[k].is_mem && mem_seen) ok = 1'b0;
         if (k != 0 && (iss.slot_i[k].is_serial || iss.slot_i[0].is_serial)) ok = 1'b0;
         legal[k] = ok;
         prev_ok  = ok;
         mem_seen = mem_seen | iss.slot_i[k].is_mem;
      end
   end

   // Oldest stage scanned first so stage 0 (and the higher lane within a stage) overrides last.
   always_comb begin
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         for (int j = 0; j < 2; j++) begin
            opnd[k][j] = iss.rf_data_i[k][j];
            for (int s = FWD_STAGES - 1; s >= 0; s--)
               for (int l = 0; l < ISSUE_WIDTH; l++)
                  if (reg_hit(iss.fwd_i[s][l].we, iss.fwd_i[s][l].addr, iss.slot_i[k].rs[j]))
                     opnd[k][j] = iss.fwd_i[s][l].data;
            if (iss.slot_i[k].rs[j] == '0) opnd[k][j] = '0;
            if (!iss.slot_i[k].rs_en[j])   opnd[k][j] = iss.slot_i[k].imm;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         issue_d[k] = '0;
         if (legal[k]) begin
            issue_d[k].valid = 1'b1;
            issue_d[k].pc    = iss.slot_i[k].pc;
            issue_d[k].op    = iss.slot_i[k].op;
            issue_d[k].src   = opnd[k];
            issue_d[k].rd    = iss.slot_i[k].rd;
            issue_d[k].rd_en = iss.slot_i[k].rd_en;
         end
         sb_set[k] = accept[k] && iss.slot_i[k].rd_en;
         sb_rd[k]  = iss.slot_i[k].rd;
         sb_lat[k] = LAT_W'(iss.slot_i[k].lat);
      end
   end

   assign accept       = go ? legal : '0;
   assign iss.accept_o = accept;
   assign iss.stall_o  = !rst && !flush && iss.slot_i[0].valid && !legal[0];
   assign iss.ex_o     = ex_p1;

   // Stage boundary: issue -> EX.
   always_ff @(posedge clk) begin
      if (rst || flush)  ex_p1 <= '0;
      else if (!pause)   ex_p1 <= issue_d;
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt_o <= '0;
      else if (iss.stall_o && !pause && stall_cnt_o != 32'hFFFF_FFFF)
         stall_cnt_o <= stall_cnt_o + 32'd1;
   end

   issue_scoreboard #(.NREGS(NREGS), .LAT_W(LAT_W), .ISSUE_WIDTH(ISSUE_WIDTH)) u_sb (
      .clk     (clk),
      .rst     (rst),
      .clr     (flush),
      .hold    (pause),
      .set_en  (sb_set),
      .set_rd  (sb_rd),
      .set_lat (sb_lat),
      .busy    (busy)
   );
endmodule

// File: tb/tb_issue_dispatch_n.sv
// Directed bench for issue_dispatch_n: prefix legality, forwarding priority, scoreboard, pause and flush.
module tb_issue_dispatch_n;
   import issue_dispatch_n_pkg::*;
   localparam int IW = 2;
   localparam int FS = 3;

   logic        clk = 1'b0;
   logic        rst, pause, flush;
   logic [31:0] stall_cnt_o;
   int          passed = 0;
   int          total  = 0;

   issue_dispatch_n_if #(.ISSUE_WIDTH(IW), .FWD_STAGES(FS)) bus ();

   issue_dispatch_n #(.ISSUE_WIDTH(IW), .FWD_STAGES(FS), .LAT_W(3), .NREGS(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .pause       (pause),
      .flush       (flush),
      .iss         (bus.slave),
      .stall_cnt_o (stall_cnt_o)
   );

   always #5 clk = ~clk;

   function automatic slot_t mk(input logic [31:0] pc, input logic [4:0] rs0, input logic en0,
                                input logic [4:0] rs1, input logic en1, input logic [4:0] rd,
                                input logic rd_en, input logic [31:0] imm, input logic [2:0] lat,
                                input logic mem, input logic ser);
      slot_t s;
      s           = '0;
      s.valid     = 1'b1;
      s.pc        = pc;
      s.rs[0]     = rs0;
      s.rs[1]     = rs1;
      s.rs_en     = {en1, en0};
      s.rd        = rd;
      s.rd_en     = rd_en;
      s.imm       = imm;
      s.lat       = lat;
      s.is_mem    = mem;
      s.is_serial = ser;
      s.op        = 8'h01;
      return s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic idle();
      bus.slot_i    = '0;
      bus.fwd_i     = '0;
      bus.rf_data_i = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; pause = 1'b0; flush = 1'b0;
      idle();
      bus.slot_i[0] = mk(32'h10, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 32'h0, 3'd1, 1'b0, 1'b0);
      @(negedge clk);
      chk("rst_accept", 32'(bus.accept_o), 32'h0);
      chk("rst_stall", 32'(bus.stall_o), 32'h0);
      next_cycle();
      @(negedge clk);
      chk("rst_ex_valid", 32'({bus.ex_o[1].valid, bus.ex_o[0].valid}), 32'h0);
      chk("rst_stall_cnt", stall_cnt_o, 32'h0);
      next_cycle();
      rst = 1'b0;

      // Two independent ALU ops issue together.
      bus.slot_i[0] = mk(32'h100, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 32'h0, 3'd1, 1'b0, 1'b0);
      bus.slot_i[1] = mk(32'h104, 5'd4, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 32'h0, 3'd1, 1'b0, 1'b0);
      bus.rf_data_i[0][0] = 32'd11; bus.rf_data_i[0][1] = 32'd22;
      bus.rf_data_i[1][0] = 32'd44; bus.rf_data_i[1][1] = 32'd55;
      @(negedge clk);
      chk("t1_accept", 32'(bus.accept_o), 32'h3);
      chk("t1_stall", 32'(bus.stall_o), 32'h0);
      next_cycle();

      // Producer of r5 in slot 0, consumer in slot 1.
      bus.slot_i[0] = mk(32'h200, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 32'h0, 3'd1, 1'b0, 1'b0);
      bus.slot_i[1] = mk(32'h204, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 32'd7, 3'd1, 1'b0, 1'b0);
      @(negedge clk);
      chk("t1_ex0_valid", 32'(bus.ex_o[0].valid), 32'h1);
      chk("t1_ex0_src0", bus.ex_o[0].src[0], 32'd11);
      chk("t1_ex0_src1", bus.ex_o[0].src[1], 32'd22);
      chk("t1_ex1_valid", 32'(bus.ex_o[1].valid), 32'h1);
      chk("t1_ex1_src1", bus.ex_o[1].src[1], 32'd55);
      chk("t1_ex1_rd", 32'(bus.ex_o[1].rd), 32'd6);
      chk("t2_accept_raw", 32'(bus.accept_o), 32'h1);
      next_cycle();

      // Consumer now in slot 0; stage 0 lane 1 must win over lane 0 and over stage 1.
      idle();
      bus.slot_i[0] = mk(32'h204, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 32'd7, 3'd1, 1'b0, 1'b0);
      bus.rf_data_i[0][0] = 32'hDEAD;
      bus.fwd_i[0][0] = '{we: 1'b1, addr: 5'd5, data: 32'h555};
      bus.fwd_i[0][1] = '{we: 1'b1, addr: 5'd5, data: 32'h666};
      bus.fwd_i[1][1] = '{we: 1'b1, addr: 5'd5, data: 32'h999};
      @(negedge clk);
      chk("t2_ex0_rd", 32'(bus.ex_o[0].rd), 32'd5);
      chk("t2_ex1_valid", 32'(bus.ex_o[1].valid), 32'h0);
      chk("t2_accept_cons", 32'(bus.accept_o), 32'h1);
      next_cycle();

      // Load r7, lat 3.
      idle();
      bus.slot_i[0] = mk(32'h300, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 32'h0, 3'd3, 1'b1, 1'b0);
      @(negedge clk);
      chk("t2_ex0_fwd", bus.ex_o[0].src[0], 32'h666);
      chk("t2_ex0_imm", bus.ex_o[0].src[1], 32'd7);
      chk("t3_accept_load", 32'(bus.accept_o), 32'h1);
      next_cycle();

      bus.slot_i[0] = mk(32'h304, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 32'h0, 3'd1, 1'b0, 1'b0);
      @(negedge clk);
      chk("t3_stall_a", 32'(bus.stall_o), 32'h1);
      chk("t3_accept_a", 32'(bus.accept_o), 32'h0);
      next_cycle();
      @(negedge clk);
      chk("t3_stall_b", 32'(bus.stall_o), 32'h1);
      next_cycle();
      @(negedge clk);
      chk("t3_accept_c", 32'(bus.accept_o), 32'h1);
      chk("t3_stall_c", 32'(bus.stall_o), 32'h0);
      chk("t3_stall_cnt", stall_cnt_o, 32'd2);
      next_cycle();

      // Load r7 again with its consumer in slot 1, then pause for 4 cycles.
      bus.slot_i[0] = mk(32'h400, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 32'h0, 3'd3, 1'b1, 1'b0);
      bus.slot_i[1] = mk(32'h404, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 32'h0, 3'd1, 1'b0, 1'b0);
      @(negedge clk);
      chk("t3_ex0_valid", 32'(bus.ex_o[0].valid), 32'h1);
      chk("t3_ex0_pc", bus.ex_o[0].pc, 32'h304);
      chk("t4_accept", 32'(bus.accept_o), 32'h1);
      next_cycle();

      idle();
      bus.slot_i[0] = mk(32'h404, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 32'h0, 3'd1, 1'b0, 1'b0);
      pause = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t4_pause_accept", 32'(bus.accept_o), 32'h0);
         chk("t4_pause_stall", 32'(bus.stall_o), 32'h1);
         chk("t4_pause_ex_hold", bus.ex_o[0].pc, 32'h400);
         chk("t4_pause_cnt", stall_cnt_o, 32'd2);
         next_cycle();
      end
      pause = 1'b0;
      @(negedge clk);
      chk("t4_stall_a", 32'(bus.stall_o), 32'h1);
      next_cycle();
      @(negedge clk);
      chk("t4_stall_b", 32'(bus.stall_o), 32'h1);
      next_cycle();
      @(negedge clk);
      chk("t4_accept_c", 32'(bus.accept_o), 32'h1);
      chk("t4_stall_cnt", stall_cnt_o, 32'd4);
      next_cycle();

      // Two memory ops share one port.
      bus.slot_i[0] = mk(32'h500, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 32'h0, 3'd1, 1'b1, 1'b0);
      bus.slot_i[1] = mk(32'h504, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 32'h0, 3'd1, 1'b1, 1'b0);
      @(negedge clk);
      chk("t5_mem_accept", 32'(bus.accept_o), 32'h1);
      next_cycle();

      bus.slot_i[0] = mk(32'h600, 5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 32'h0, 3'd1, 1'b0, 1'b0);
      bus.slot_i[1] = mk(32'h604, 5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 32'h0, 3'd1, 1'b0, 1'b1);
      @(negedge clk);
      chk("t5_ser1_accept", 32'(bus.accept_o), 32'h1);
      next_cycle();

      bus.slot_i[0] = mk(32'h604, 5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 32'h0, 3'd1, 1'b0, 1'b1);
      bus.slot_i[1] = mk(32'h608, 5'd1, 1'b1, 5'd2, 1'b1, 5'd13, 1'b1, 32'h0, 3'd1, 1'b0, 1'b0);
      @(negedge clk);
      chk("t5_ser0_accept", 32'(bus.accept_o), 32'h1);
      next_cycle();

      idle();
      bus.slot_i[0] = mk(32'h608, 5'd1, 1'b1, 5'd2, 1'b1, 5'd13, 1'b1, 32'h0, 3'd1, 1'b0, 1'b0);
      @(negedge clk);
      chk("t5_ser0_ex_pc", bus.ex_o[0].pc, 32'h604);
      chk("t5_ser0_ex1_valid", 32'(bus.ex_o[1].valid), 32'h0);
      chk("t5_after_accept", 32'(bus.accept_o), 32'h1);
      next_cycle();

      // Load r9 lat 6, then flush while its counter is 5.
      bus.slot_i[0] = mk(32'h700, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 32'h0, 3'd6, 1'b1, 1'b0);
      @(negedge clk);
      chk("t6_load_accept", 32'(bus.accept_o), 32'h1);
      next_cycle();

      bus.slot_i[0] = mk(32'h704, 5'd9, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 32'h0, 3'd1, 1'b0, 1'b0);
      flush = 1'b1;
      @(negedge clk);
      chk("t6_flush_accept", 32'(bus.accept_o), 32'h0);
      chk("t6_flush_stall", 32'(bus.stall_o), 32'h0);
      chk("t6_flush_ex_pc", bus.ex_o[0].pc, 32'h700);
      next_cycle();

      flush = 1'b0;
      @(negedge clk);
      chk("t6_ex_cleared", 32'(bus.ex_o[0].valid), 32'h0);
      chk("t6_accept", 32'(bus.accept_o), 32'h1);
      chk("t6_stall", 32'(bus.stall_o), 32'h0);
      next_cycle();

      idle();
      @(negedge clk);
      chk("t6_ex0_valid", 32'(bus.ex_o[0].valid), 32'h1);
      chk("t6_ex0_pc", bus.ex_o[0].pc, 32'h704);
      chk("t6_stall_cnt_kept", stall_cnt_o, 32'd4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
